hr_lut_fetch: RTL and testbench
===============================

HR_LUT_FETCH -- requirements
Module: hr_lut_fetch

Interface
- REQ-001: Parameter IN_ADDR, default 8'd249, is the bus address of the beat-count input port.
- REQ-002: Parameter LUT_BASE, default 8'd0, is the bus address of LUT entry 0; each entry is a 2-byte BCD word, low byte first.
- REQ-003: Parameter OUT_LO, default 8'd252, is the bus address of the display low-byte output register.
- REQ-004: Parameter OUT_HI, default 8'd253, is the bus address of the display high-byte output register.
- REQ-005: Parameter MAX_IDX, default 8'd29, is the highest valid LUT index.
- REQ-006: Ports SHALL be as follows; one clock; reset is synchronous and active-high:
  - CLK  input  1  clock; all state changes on rising edge.
  - RESET  input  1  synchronous active-high reset.
  - START  input  1  fetch request; sampled only in IDLE.
  - Q  input  8  bus read data; combinational from ADDR.
  - ADDR  output  8  bus address.
  - DATA  output  8  bus write data.
  - MW  output  1  bus write enable; a write commits at the rising edge that ends the cycle in which MW=1.
  - BUSY  output  1  high in every state except IDLE.
  - DONE  output  1  one-cycle completion pulse.
  - SAT  output  1  input count exceeded MAX_IDX on the last fetch.

Function
- REQ-007: The FSM SHALL have the states IDLE, RD_IN, RD_LO, RD_HI, WR_LO, WR_HI and FIN, with one bus cycle per state.
- REQ-008: In IDLE, a START=1 sampled at a rising edge SHALL move the FSM to RD_IN; in IDLE with START=0 the FSM SHALL stay in IDLE.
- REQ-009: RD_IN SHALL drive ADDR=IN_ADDR and MW=0, and SHALL capture cnt=Q at the edge that ends the state.
- REQ-010: At that same edge, idx SHALL be set to min(cnt, MAX_IDX) and SAT SHALL be set to (cnt > MAX_IDX); SAT holds until the next RD_IN or reset.
- REQ-011: RD_LO SHALL drive ADDR=LUT_BASE+2*idx and MW=0, and SHALL capture lo=Q.
- REQ-012: RD_HI SHALL drive ADDR=LUT_BASE+2*idx+1 and MW=0, and SHALL capture hi=Q.
- REQ-013: All address arithmetic SHALL be 8-bit modulo 256 (wrap-around, no error).
- REQ-014: WR_LO SHALL drive ADDR=OUT_LO, DATA=lo and MW=1.
- REQ-015: WR_HI SHALL drive ADDR=OUT_HI, DATA=hi and MW=1.
- REQ-016: FIN SHALL assert DONE=1 with MW=0 for exactly one cycle, then move to IDLE.
- REQ-017: The transition sequence SHALL be fixed: RD_IN -> RD_LO -> RD_HI -> WR_LO -> WR_HI -> FIN -> IDLE.
- REQ-018: Latency SHALL be: START sampled at edge k, DONE high during the cycle after edge k+5.
- REQ-019: START while BUSY=1, including during FIN, SHALL be ignored and not queued.
- REQ-020: In IDLE, outputs SHALL be ADDR=0, DATA=0, MW=0, BUSY=0 and DONE=0.
- REQ-021: MW SHALL be 1 only in WR_LO and WR_HI; ADDR, DATA and MW SHALL be glitch-free registered or state-decoded outputs.

Reset
- REQ-022: RESET=1 at a rising edge SHALL force IDLE, ADDR=0, DATA=0, MW=0, BUSY=0, DONE=0, SAT=0 and cnt=idx=lo=hi=0.
- REQ-023: RESET SHALL take priority over START and over any in-progress state.
- REQ-024: RESET asserted mid-fetch SHALL abort the fetch; no bus write SHALL occur in the cycle following the reset edge.
- REQ-025: After a reset, the only write-side effects SHALL be writes already committed before the reset edge.

Verification
- REQ-026: Port 249=5, memory LUT loaded (mem[10]=0x44, mem[11]=0x00), START pulse -> reads at addresses 249, 10, 11; writes 252<=0x44, 253<=0x00; DONE 6 cycles after START; SAT=0.
- REQ-027: Port 249=29 -> reads at addresses 58 and 59; writes 252<=0x59, 253<=0x02; SAT=0.
- REQ-028: Port 249=200 -> idx clamped to 29; same writes as REQ-027; SAT=1 until the next fetch.
- REQ-029: START held high for 10 cycles -> exactly one fetch during its first 6 cycles; a second fetch starts only after return to IDLE.
- REQ-030: RESET asserted during WR_LO -> MW=0 in the next cycle; 253 unchanged; BUSY=0; DONE never pulses.
- REQ-031: LUT_BASE=8'd250 with idx=3 -> read addresses 0 and 1 (wrap-around); no hang.

Source files
------------

// File: rtl/hr_lut_fetch.sv
// hr_lut_fetch: reads a beat count, looks up its 2-byte BCD word in a bus LUT, writes it to the display registers
// Ports: CLK/RESET (sync, active-high); START begins a fetch from IDLE; Q is combinational bus read data;
// ADDR/DATA/MW drive the bus; BUSY is high outside IDLE; DONE pulses for one cycle; SAT flags a clamped count.
module hr_lut_fetch #(
  parameter logic [7:0] IN_ADDR  = 8'd249,
  parameter logic [7:0] LUT_BASE = 8'd0,
  parameter logic [7:0] OUT_LO   = 8'd252,
  parameter logic [7:0] OUT_HI   = 8'd253,
  parameter logic [7:0] MAX_IDX  = 8'd29
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] Q,
  output logic [7:0] ADDR,
  output logic [7:0] DATA,
  output logic       MW,
  output logic       BUSY,
  output logic       DONE,
  output logic       SAT
);
  typedef enum logic [2:0] {IDLE, RD_IN, RD_LO, RD_HI, WR_LO, WR_HI, FIN} state_t;
  state_t state, state_nx;
  logic [7:0] idx, lo, hi, lut_addr;
  assign lut_addr = LUT_BASE + (idx << 1);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
      lo    <= '0;
      hi    <= '0;
      SAT   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == RD_IN) begin
        idx <= (Q > MAX_IDX) ? MAX_IDX : Q;
        SAT <= Q > MAX_IDX;
      end
      if (state == RD_LO) lo <= Q;
      if (state == RD_HI) hi <= Q;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (START ? RD_IN : IDLE) :
               state == FIN  ? IDLE : state_t'(state + 3'd1);
    ADDR = state == RD_IN ? IN_ADDR :
           state == RD_LO ? lut_addr :
           state == RD_HI ? lut_addr + 8'd1 :
           state == WR_LO ? OUT_LO :
           state == WR_HI ? OUT_HI : 8'd0;
    DATA = state == WR_LO ? lo : state == WR_HI ? hi : 8'd0;
    MW   = state == WR_LO || state == WR_HI;
    BUSY = state != IDLE;
    DONE = state == FIN;
  end
endmodule

// File: tb/tb_hr_lut_fetch.sv
// tb_hr_lut_fetch: table-driven and scoreboard bench for hr_lut_fetch with a bus memory model
module tb_hr_lut_fetch;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET, START, START2, MW, BUSY, DONE, SAT, MW2, BUSY2, DONE2, SAT2;
  logic [7:0] Q, ADDR, DATA, Q2, ADDR2, DATA2;
  logic [7:0] mem [256];
  logic [7:0] mem2 [256];
  assign Q  = mem[ADDR];
  assign Q2 = mem2[ADDR2];
  always @(posedge CLK) begin
    if (MW) mem[ADDR] <= DATA;
    if (MW2) mem2[ADDR2] <= DATA2;
  end
  hr_lut_fetch dut (.CLK(CLK), .RESET(RESET), .START(START), .Q(Q), .ADDR(ADDR),
    .DATA(DATA), .MW(MW), .BUSY(BUSY), .DONE(DONE), .SAT(SAT));
  hr_lut_fetch #(.LUT_BASE(8'd250)) dut2 (.CLK(CLK), .RESET(RESET), .START(START2), .Q(Q2),
    .ADDR(ADDR2), .DATA(DATA2), .MW(MW2), .BUSY(BUSY2), .DONE(DONE2), .SAT(SAT2));
  int n_cmp = 0, n_bad = 0;
  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  logic [7:0]  rd_q [$];
  logic [15:0] wr_q [$];
  logic        sat_q [$];
  always @(negedge CLK) begin : mon
    logic [15:0] w;
    if (MW) begin
      if (wr_q.size() == 0) chk("unexpected_write", int'(ADDR), -1);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", int'(ADDR), int'(w[15:8]));
        chk("wr_data", int'(DATA), int'(w[7:0]));
      end
    end else if (DONE) begin
      if (sat_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("sat_at_done", int'(SAT), int'(sat_q.pop_front()));
    end else if (BUSY) begin
      if (rd_q.size() == 0) chk("unexpected_read", int'(ADDR), -1);
      else chk("rd_addr", int'(ADDR), int'(rd_q.pop_front()));
    end
  end
  task automatic fetch_expect(input logic [7:0] idx, input logic sat, input bit full);
    logic [7:0] a;
    a = idx << 1;
    rd_q.push_back(8'd249);
    rd_q.push_back(a);
    rd_q.push_back(a + 8'd1);
    wr_q.push_back({8'd252, mem[a]});
    if (full) begin
      wr_q.push_back({8'd253, mem[a + 8'd1]});
      sat_q.push_back(sat);
    end
  endtask
  task automatic start_pulse();
    @(posedge CLK) #1 START = 1'b1;
    @(posedge CLK) #1 START = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = c;
        break;
      end
    end
  endtask
  typedef struct {logic [7:0] cnt; logic [7:0] idx; logic sat;} vec_t;
  vec_t vt [7];
  logic [7:0] wexp [6];
  initial begin
    int lat, dn, t1, t2;
    vt[0] = '{8'd5, 8'd5, 1'b0};
    vt[1] = '{8'd29, 8'd29, 1'b0};
    vt[2] = '{8'd200, 8'd29, 1'b1};
    vt[3] = '{8'd0, 8'd0, 1'b0};
    vt[4] = '{8'd17, 8'd17, 1'b0};
    vt[5] = '{8'd30, 8'd29, 1'b1};
    vt[6] = '{8'd255, 8'd29, 1'b1};
    wexp = '{8'd249, 8'd0, 8'd1, 8'd252, 8'd253, 8'd0};
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'hFF;
      mem2[i] = 8'hFF;
    end
    for (int i = 0; i < 30; i++) begin
      mem[2*i] = 8'(i * 3 + 7);
      mem[2*i+1] = 8'(i + 96);
    end
    mem[10] = 8'h44; mem[11] = 8'h00; mem[58] = 8'h59; mem[59] = 8'h02;
    RESET = 1'b1; START = 1'b0; START2 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_addr", int'(ADDR), 0);
    chk("rst_data", int'(DATA), 0);
    chk("rst_mw", int'(MW), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_sat", int'(SAT), 0);
    START = 1'b1;
    @(posedge CLK) #1;
    chk("rst_over_start", int'(BUSY), 0);
    START = 1'b0;
    RESET = 1'b0;
    foreach (vt[i]) begin
      mem[249] = vt[i].cnt; mem[252] = 8'hA5; mem[253] = 8'h5A;
      fetch_expect(vt[i].idx, vt[i].sat, 1'b1);
      start_pulse();
      wait_done(lat);
      chk("latency", lat, 6);
      @(negedge CLK);
      chk("sat_hold", int'(SAT), int'(vt[i].sat));
      chk("idle_busy", int'(BUSY), 0);
      chk("idle_addr", int'(ADDR), 0);
      chk("out_lo", int'(mem[252]), int'(mem[8'(vt[i].idx << 1)]));
      chk("out_hi", int'(mem[253]), int'(mem[8'(vt[i].idx << 1) + 8'd1]));
    end
    mem[249] = 8'd5;
    fetch_expect(8'd5, 1'b0, 1'b1);
    fetch_expect(8'd5, 1'b0, 1'b1);
    dn = 0; t1 = 0; t2 = 0;
    @(posedge CLK) #1 START = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (DONE) begin
        dn++;
        if (dn == 1) t1 = c; else t2 = c;
      end
      if (c == 11) START = 1'b0;
    end
    chk("held_done_count", dn, 2);
    chk("held_first_done", t1, 7);
    chk("held_second_done", t2, 14);
    mem[249] = 8'd17; mem[253] = 8'hEE;
    fetch_expect(8'd17, 1'b0, 1'b0);
    start_pulse();
    repeat (4) @(negedge CLK);
    chk("mw_in_wr_lo", int'(MW), 1);
    #1 RESET = 1'b1;
    @(posedge CLK) #1 RESET = 1'b0;
    @(negedge CLK);
    chk("abort_mw", int'(MW), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_sat", int'(SAT), 0);
    dn = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_hi_kept", int'(mem[253]), 8'hEE);
    mem2[249] = 8'd3; mem2[0] = 8'hAB; mem2[1] = 8'hCD; mem2[252] = 8'h00; mem2[253] = 8'h00;
    @(posedge CLK) #1 START2 = 1'b1;
    @(posedge CLK) #1 START2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("wrap_addr", int'(ADDR2), int'(wexp[c]));
    end
    chk("wrap_done", int'(DONE2), 1);
    @(negedge CLK);
    chk("wrap_lo", int'(mem2[252]), 8'hAB);
    chk("wrap_hi", int'(mem2[253]), 8'hCD);
    chk("wrap_idle", int'(BUSY2), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("sat_q_left", sat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
